// File: rtl/issue_ctrl_pkg.sv
// Shared types for the issue controller: ISA constants, decoded bundle,
// queue entry layout and controller state encodings.
package issue_ctrl_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  typedef logic [31:0]      ins_t;
  typedef logic [XLEN-1:0]  data_t;
  typedef logic [REG_W-1:0] reg_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_0 = 3'b000;
  localparam logic [2:0] F3_1 = 3'b001;
  localparam logic [2:0] F3_2 = 3'b010;
  localparam logic [2:0] F3_3 = 3'b011;
  localparam logic [2:0] F3_4 = 3'b100;
  localparam logic [2:0] F3_5 = 3'b101;
  localparam logic [2:0] F3_6 = 3'b110;
  localparam logic [2:0] F3_7 = 3'b111;

  typedef enum logic [5:0] {
    OP_NOP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
    OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND
  } openum_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } iq_state_t;

  typedef struct packed {
    ins_t  inst;
    data_t pc;
    logic  pred_jump;
  } iq_entry_t;

  localparam int IQ_ENTRY_W = $bits(iq_entry_t);

  typedef struct packed {
    openum_t openum;
    reg_t    rd;
    reg_t    rs1;
    reg_t    rs2;
    data_t   imm;
    logic    is_ls;
    logic    is_ctrl;
  } dec_t;

  function automatic data_t sext12(input logic [11:0] v);
    return {{(XLEN-12){v[11]}}, v};
  endfunction

endpackage

// File: rtl/issue_ctrl_decoder.sv
// Combinational RV32I decoder: opcode class, register fields, immediate,
// and load/store / control-flow flags for issue routing.
module issue_ctrl_decoder
  import issue_ctrl_pkg::*;
(
  input  ins_t inst,
  output dec_t dec
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic       alt;
  reg_t       rd_f;
  reg_t       rs1_f;
  reg_t       rs2_f;
  data_t      imm_i;
  data_t      imm_s;
  data_t      imm_b;
  data_t      imm_u;
  data_t      imm_j;

  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign alt   = inst[30];
  assign rd_f  = inst[11:7];
  assign rs1_f = inst[19:15];
  assign rs2_f = inst[24:20];

  assign imm_i = sext12(inst[31:20]);
  assign imm_s = sext12({inst[31:25], inst[11:7]});
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                  inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                  inst[20], inst[30:21], 1'b0};

  always_comb begin
    dec = '0;
    unique case (1'b1)
      opc == OPC_LUI: begin
        dec.openum = OP_LUI;
        dec.rd     = rd_f;
        dec.imm    = imm_u;
      end
      opc == OPC_AUIPC: begin
        dec.openum = OP_AUIPC;
        dec.rd     = rd_f;
        dec.imm    = imm_u;
      end
      opc == OPC_JAL: begin
        dec.openum  = OP_JAL;
        dec.rd      = rd_f;
        dec.imm     = imm_j;
        dec.is_ctrl = 1'b1;
      end
      opc == OPC_JALR: begin
        dec.openum  = OP_JALR;
        dec.rd      = rd_f;
        dec.rs1     = rs1_f;
        dec.imm     = imm_i;
        dec.is_ctrl = 1'b1;
      end
      opc == OPC_BRANCH: begin
        dec.rs1     = rs1_f;
        dec.rs2     = rs2_f;
        dec.imm     = imm_b;
        dec.is_ctrl = 1'b1;
        case (f3)
          F3_0:    dec.openum = OP_BEQ;
          F3_1:    dec.openum = OP_BNE;
          F3_4:    dec.openum = OP_BLT;
          F3_5:    dec.openum = OP_BGE;
          F3_6:    dec.openum = OP_BLTU;
          F3_7:    dec.openum = OP_BGEU;
          default: dec.openum = OP_NOP;
        endcase
      end
      opc == OPC_LOAD: begin
        dec.rd    = rd_f;
        dec.rs1   = rs1_f;
        dec.imm   = imm_i;
        dec.is_ls = 1'b1;
        case (f3)
          F3_0:    dec.openum = OP_LB;
          F3_1:    dec.openum = OP_LH;
          F3_2:    dec.openum = OP_LW;
          F3_4:    dec.openum = OP_LBU;
          F3_5:    dec.openum = OP_LHU;
          default: dec.openum = OP_NOP;
        endcase
      end
      opc == OPC_STORE: begin
        dec.rs1   = rs1_f;
        dec.rs2   = rs2_f;
        dec.imm   = imm_s;
        dec.is_ls = 1'b1;
        case (f3)
          F3_0:    dec.openum = OP_SB;
          F3_1:    dec.openum = OP_SH;
          F3_2:    dec.openum = OP_SW;
          default: dec.openum = OP_NOP;
        endcase
      end
      opc == OPC_OPIMM: begin
        dec.rd  = rd_f;
        dec.rs1 = rs1_f;
        dec.imm = imm_i;
        case (f3)
          F3_0:    dec.openum = OP_ADDI;
          F3_1:    dec.openum = OP_SLLI;
          F3_2:    dec.openum = OP_SLTI;
          F3_3:    dec.openum = OP_SLTIU;
          F3_4:    dec.openum = OP_XORI;
          F3_5:    dec.openum = alt ? OP_SRAI : OP_SRLI;
          F3_6:    dec.openum = OP_ORI;
          default: dec.openum = OP_ANDI;
        endcase
      end
      opc == OPC_OP: begin
        dec.rd  = rd_f;
        dec.rs1 = rs1_f;
        dec.rs2 = rs2_f;
        case (f3)
          F3_0:    dec.openum = alt ? OP_SUB : OP_ADD;
          F3_1:    dec.openum = OP_SLL;
          F3_2:    dec.openum = OP_SLT;
          F3_3:    dec.openum = OP_SLTU;
          F3_4:    dec.openum = OP_XOR;
          F3_5:    dec.openum = alt ? OP_SRA : OP_SRL;
          F3_6:    dec.openum = OP_OR;
          default: dec.openum = OP_AND;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/issue_ctrl.sv
// In-order instruction queue with RS/LSB routing and RUN/STALL/FLUSH control.
// Optional IQ_BYPASS_EN lets a word reaching an empty queue issue immediately.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int IQ_DEPTH = 8
) (
  input  logic    clk_in,
  input  logic    rst_n_in,
  input  logic    rdy_in,
  input  logic    fetch_valid,
  input  ins_t    fetch_inst,
  input  data_t   fetch_pc,
  input  logic    fetch_pred_jump,
  output logic    iq_full,
  input  logic    rob_full,
  input  logic    rs_full,
  input  logic    lsb_full,
  input  logic    rollback,
  output logic    issue_valid,
  output logic    issue_to_rs,
  output logic    issue_to_lsb,
  output logic    issue_is_ctrl,
  output openum_t issue_openum,
  output reg_t    issue_rd,
  output reg_t    issue_rs1,
  output reg_t    issue_rs2,
  output data_t   issue_imm,
  output data_t   issue_pc,
  output logic    issue_pred_jump
);

  localparam int PW = $clog2(IQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(IQ_DEPTH);
  localparam logic [CW-1:0] ALMOST_C = CW'(IQ_DEPTH - 1);
  localparam logic [PW-1:0] ONE_P    = PW'(1);

  iq_entry_t     iq_mem [IQ_DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  iq_state_t     state_q;

  iq_entry_t fetch_e;
  iq_entry_t src_e;
  dec_t      dec;
  logic      empty;
  logic      fetch_ok;
  logic      use_fetch;
  logic      have_src;
  logic      tgt_full;
  logic      blocked;
  logic      fire;
  logic      push;
  logic      pop;

  assign fetch_e = '{inst: fetch_inst,
                     pc: fetch_pc,
                     pred_jump: fetch_pred_jump};

  assign empty    = (count_q == '0);
  assign iq_full  = (count_q >= ALMOST_C);
  assign fetch_ok = rdy_in && fetch_valid
                 && (count_q < DEPTH_C)
                 && (state_q != ST_FLUSH)
                 && !rollback;

`ifdef IQ_BYPASS_EN
  assign use_fetch = empty && fetch_ok;
`else
  assign use_fetch = 1'b0;
`endif

  assign src_e    = use_fetch ? fetch_e : iq_mem[head_q];
  assign have_src = !empty || use_fetch;

  issue_ctrl_decoder u_dec (
    .inst (src_e.inst),
    .dec  (dec)
  );

  assign tgt_full = dec.is_ls ? lsb_full : rs_full;
  assign blocked  = rob_full || tgt_full;
  assign fire     = rdy_in && !rollback
                 && (state_q == ST_RUN)
                 && have_src && !blocked;
  assign pop      = fire && !use_fetch;
  // A bypassed word that issues is never written into storage.
  assign push     = fetch_ok && !(fire && use_fetch);

  always_ff @(posedge clk_in) begin
    if (rst_n_in && push)
      iq_mem[tail_q] <= fetch_e;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      state_q         <= ST_RUN;
      issue_valid     <= 1'b0;
      issue_to_rs     <= 1'b0;
      issue_to_lsb    <= 1'b0;
      issue_is_ctrl   <= 1'b0;
      issue_openum    <= OP_NOP;
      issue_rd        <= '0;
      issue_rs1       <= '0;
      issue_rs2       <= '0;
      issue_imm       <= '0;
      issue_pc        <= '0;
      issue_pred_jump <= 1'b0;
    end else if (rdy_in) begin
      issue_valid   <= fire;
      issue_to_rs   <= fire && !dec.is_ls;
      issue_to_lsb  <= fire && dec.is_ls;
      issue_is_ctrl <= fire && dec.is_ctrl;
      if (fire) begin
        issue_openum    <= dec.openum;
        issue_rd        <= dec.rd;
        issue_rs1       <= dec.rs1;
        issue_rs2       <= dec.rs2;
        issue_imm       <= dec.imm;
        issue_pc        <= src_e.pc;
        issue_pred_jump <= src_e.pred_jump;
      end
      if (rollback) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        state_q <= ST_FLUSH;
      end else begin
        if (push)
          tail_q <= tail_q + ONE_P;
        if (pop)
          head_q <= head_q + ONE_P;
        count_q <= count_q + CW'(push) - CW'(pop);
        case (state_q)
          ST_RUN:
            if (have_src && blocked)
              state_q <= ST_STALL;
          ST_STALL:
            if (!(have_src && blocked))
              state_q <= ST_RUN;
          default:
            state_q <= ST_RUN;
        endcase
      end
    end else begin
      issue_valid   <= 1'b0;
      issue_to_rs   <= 1'b0;
      issue_to_lsb  <= 1'b0;
      issue_is_ctrl <= 1'b0;
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed self-checking bench for issue_ctrl (default IQ_DEPTH=8).
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n;
  logic    rdy;
  logic    fetch_valid;
  ins_t    fetch_inst;
  data_t   fetch_pc;
  logic    fetch_pred_jump;
  logic    iq_full;
  logic    rob_full;
  logic    rs_full;
  logic    lsb_full;
  logic    rollback;
  logic    issue_valid;
  logic    issue_to_rs;
  logic    issue_to_lsb;
  logic    issue_is_ctrl;
  openum_t issue_openum;
  reg_t    issue_rd;
  reg_t    issue_rs1;
  reg_t    issue_rs2;
  data_t   issue_imm;
  data_t   issue_pc;
  logic    issue_pred_jump;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  issue_ctrl #(.IQ_DEPTH(8)) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .rdy_in          (rdy),
    .fetch_valid     (fetch_valid),
    .fetch_inst      (fetch_inst),
    .fetch_pc        (fetch_pc),
    .fetch_pred_jump (fetch_pred_jump),
    .iq_full         (iq_full),
    .rob_full        (rob_full),
    .rs_full         (rs_full),
    .lsb_full        (lsb_full),
    .rollback        (rollback),
    .issue_valid     (issue_valid),
    .issue_to_rs     (issue_to_rs),
    .issue_to_lsb    (issue_to_lsb),
    .issue_is_ctrl   (issue_is_ctrl),
    .issue_openum    (issue_openum),
    .issue_rd        (issue_rd),
    .issue_rs1       (issue_rs1),
    .issue_rs2       (issue_rs2),
    .issue_imm       (issue_imm),
    .issue_pc        (issue_pc),
    .issue_pred_jump (issue_pred_jump)
  );

  function automatic ins_t addi(input int rd, input int imm);
    logic [11:0] i12;
    logic [4:0]  r5;
    i12 = 12'(imm);
    r5  = 5'(rd);
    return {i12, 5'd0, 3'b000, r5, 7'b0010011};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; rdy = 1; fetch_valid = 0;
    fetch_inst = '0; fetch_pc = '0; fetch_pred_jump = 0;
    rob_full = 0; rs_full = 0; lsb_full = 0; rollback = 0;
    step(); step();
    check("rst_valid", issue_valid, 0);
    check("rst_full", iq_full, 0);
    check("rst_count", dut.count_q, 0);
    check("rst_state", dut.state_q, ST_RUN);
    check("rst_pc", issue_pc, 0);
    rst_n = 1;

    // Fill 8 ADDIs while the ROB is full, then drain in order.
    rob_full = 1;
    for (int i = 0; i < 8; i++) begin
      fetch_valid = 1;
      fetch_inst  = addi(i + 1, i + 1);
      fetch_pc    = 32'h100 + 32'(4 * i);
      step();
      if (i == 5) check("full_at6", iq_full, 0);
      if (i == 6) check("full_at7", iq_full, 1);
      check("fill_noissue", issue_valid, 0);
    end
    check("fill_count", dut.count_q, 8);
    check("fill_state", dut.state_q, ST_STALL);
    fetch_inst = addi(20, 20);
    step();
    check("drop_when_full", dut.count_q, 8);
    fetch_valid = 0;
    rob_full = 0;
    step();
    check("unstall_state", dut.state_q, ST_RUN);
    check("unstall_noissue", issue_valid, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("drain_valid", issue_valid, 1);
      check("drain_rd", issue_rd, i + 1);
      check("drain_imm", issue_imm, i + 1);
      check("drain_pc", issue_pc, 32'h100 + 32'(4 * i));
      check("drain_rs", issue_to_rs, 1);
    end
    step();
    check("drain_end_valid", issue_valid, 0);
    check("drain_end_count", dut.count_q, 0);

    // LW blocked by lsb_full.
    lsb_full = 1;
    fetch_valid = 1;
    fetch_inst = 32'h0001_2083;
    fetch_pc = 32'h400;
    step();
    fetch_valid = 0;
    step(); step();
    check("lw_stall", dut.state_q, ST_STALL);
    check("lw_noissue", issue_valid, 0);
    lsb_full = 0;
    step();
    check("lw_run", dut.state_q, ST_RUN);
    step();
    check("lw_valid", issue_valid, 1);
    check("lw_lsb", issue_to_lsb, 1);
    check("lw_rs", issue_to_rs, 0);
    check("lw_op", issue_openum, OP_LW);
    check("lw_rd", issue_rd, 1);
    check("lw_rs1", issue_rs1, 2);
    check("lw_imm", issue_imm, 0);
    step();

    // Rollback with 5 queued and a word on the fetch port.
    rs_full = 1;
    for (int i = 0; i < 5; i++) begin
      fetch_valid = 1;
      fetch_inst = addi(i + 1, i);
      fetch_pc = 32'h800 + 32'(4 * i);
      step();
    end
    check("rb_pre_count", dut.count_q, 5);
    rollback = 1;
    fetch_inst = addi(30, 30);
    step();
    check("rb_count", dut.count_q, 0);
    check("rb_state", dut.state_q, ST_FLUSH);
    check("rb_valid", issue_valid, 0);
    rollback = 0;
    step();
    check("flush_drop", dut.count_q, 0);
    check("flush_run", dut.state_q, ST_RUN);
    rs_full = 0;
    fetch_inst = addi(9, 9);
    fetch_pc = 32'h900;
    step();
    fetch_valid = 0;
`ifndef IQ_BYPASS_EN
    check("post_rb_wait", issue_valid, 0);
    step();
`endif
    check("post_rb_valid", issue_valid, 1);
    check("post_rb_rd", issue_rd, 9);
    check("post_rb_pc", issue_pc, 32'h900);
    step();

    // Steady push+pop at count 7 with pointer wrap.
    rob_full = 1;
    for (int n = 0; n < 7; n++) begin
      fetch_valid = 1;
      fetch_inst = addi(n + 1, n);
      fetch_pc = 32'h2000 + 32'(4 * n);
      step();
    end
    check("ss_count7", dut.count_q, 7);
    fetch_valid = 0;
    rob_full = 0;
    step();
    for (int j = 0; j < 20; j++) begin
      fetch_valid = 1;
      fetch_inst = addi(j + 8, j + 7);
      fetch_pc = 32'h2000 + 32'(4 * (j + 7));
      step();
      check("ss_valid", issue_valid, 1);
      check("ss_pc", issue_pc, 32'h2000 + 32'(4 * j));
      check("ss_count", dut.count_q, 7);
    end
    fetch_valid = 0;
    for (int j = 20; j < 27; j++) begin
      step();
      check("ss_tail_pc", issue_pc, 32'h2000 + 32'(4 * j));
      check("ss_tail_rd", issue_rd, j + 1);
    end
    step();
    check("ss_empty", dut.count_q, 0);

    // rdy_in freeze mid-stream, then reset.
    rob_full = 1;
    for (int n = 0; n < 4; n++) begin
      fetch_valid = 1;
      fetch_inst = addi(n + 1, n);
      fetch_pc = 32'h3000 + 32'(4 * n);
      step();
    end
    fetch_valid = 0;
    rob_full = 0;
    step(); step();
    check("frz_pre_valid", issue_valid, 1);
    check("frz_pre_count", dut.count_q, 3);
    rdy = 0;
    fetch_valid = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("frz_valid", issue_valid, 0);
      check("frz_count", dut.count_q, 3);
      check("frz_state", dut.state_q, ST_RUN);
    end
    rst_n = 0;
    step();
    check("rst2_count", dut.count_q, 0);
    check("rst2_valid", issue_valid, 0);
    check("rst2_pc", issue_pc, 0);
    check("rst2_full", iq_full, 0);
    fetch_valid = 0;
    rdy = 1;
    rst_n = 1;
    step();
    check("rst2_discard", issue_valid, 0);

    // JAL into an empty queue.
    fetch_valid = 1;
    fetch_inst = 32'h0080_00EF;
    fetch_pc = 32'h5000;
    fetch_pred_jump = 1;
    step();
    fetch_valid = 0;
    fetch_pred_jump = 0;
`ifndef IQ_BYPASS_EN
    check("jal_wait", issue_valid, 0);
    step();
`endif
    check("jal_valid", issue_valid, 1);
    check("jal_ctrl", issue_is_ctrl, 1);
    check("jal_op", issue_openum, OP_JAL);
    check("jal_imm", issue_imm, 8);
    check("jal_rd", issue_rd, 1);
    check("jal_pred", issue_pred_jump, 1);
    step();
    check("jal_done", issue_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
